// File: rtl/state_pack_cit_polyvec_seq_if.sv
// Bundle between the polyvec pack sequencer and its surroundings:
// controller pulses, coefficient RAM read port, group packer and
// ciphertext byte RAM write port.
`timescale 1ns/1ps
interface state_pack_cit_polyvec_seq_if #(
  parameter int COEF_W  = 12,
  parameter int GRP_W   = 40,
  parameter int GADDR_W = 7,
  parameter int BADDR_W = 10
);
  // Handshake semantics: there is no valid/ready back-pressure here.
  // start, clear, pk_enable, pk_clear, pk_done and done are single-cycle
  // pulses sampled on the rising edge. coef_rd_data is valid the cycle
  // after coef_rd_en. pk_coeffs is held from the pk_enable cycle until
  // pk_done. pk_group is valid in the pk_done cycle. Every ct_we cycle
  // is one byte write of ct_wdata to ct_addr.
  logic                 start;
  logic                 clear;
  logic                 busy;
  logic                 done;
  logic                 coef_rd_en;
  logic [GADDR_W-1:0]   coef_addr;
  logic [4*COEF_W-1:0]  coef_rd_data;
  logic                 pk_enable;
  logic                 pk_clear;
  logic [4*COEF_W-1:0]  pk_coeffs;
  logic                 pk_done;
  logic [GRP_W-1:0]     pk_group;
  logic                 ct_we;
  logic [BADDR_W-1:0]   ct_addr;
  logic [7:0]           ct_wdata;
  logic [2:0]           dbg_state;

  // Sequencer side
  modport master (
    input  start, clear, coef_rd_data, pk_done, pk_group,
    output busy, done, coef_rd_en, coef_addr, pk_enable, pk_clear,
           pk_coeffs, ct_we, ct_addr, ct_wdata, dbg_state
  );

  // Environment side (controller, RAMs, packer)
  modport slave (
    output start, clear, coef_rd_data, pk_done, pk_group,
    input  busy, done, coef_rd_en, coef_addr, pk_enable, pk_clear,
           pk_coeffs, ct_we, ct_addr, ct_wdata, dbg_state
  );
endinterface

// File: rtl/state_pack_cit_polyvec_seq.sv
// Packs the compressed polyvec u into the leading ciphertext bytes.
// For each 4-coefficient group: read the word, launch the shared group
// packer, wait for its 40-bit result, then write it as 5 bytes MSB-first.
`timescale 1ns/1ps
module state_pack_cit_polyvec_seq #(
  parameter int KYBER_K = 2,
  parameter int KYBER_N = 256,
  parameter int COEF_W  = 12,
  parameter int GRP_W   = 40,
  parameter int GADDR_W = 7,
  parameter int BADDR_W = 10
) (
  input logic clk,
  input logic reset_n,
  state_pack_cit_polyvec_seq_if.master bus
);

  localparam int NG = KYBER_K * KYBER_N / 4;
  localparam logic [GADDR_W-1:0] G_LAST = GADDR_W'(NG - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RDW    = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAITP  = 3'd4,
    S_WR     = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t               r_state;
  logic [GADDR_W-1:0]   r_g;
  logic [2:0]           r_j;
  // Holds the not-yet-written bytes of the group, next byte in the top 8 bits
  logic [GRP_W-1:0]     r_grp;

  logic                 r_busy;
  logic                 r_done;
  logic                 r_coef_rd_en;
  logic [GADDR_W-1:0]   r_coef_addr;
  logic                 r_pk_enable;
  logic                 r_pk_clear;
  logic [4*COEF_W-1:0]  r_pk_coeffs;
  logic                 r_ct_we;
  logic [BADDR_W-1:0]   r_ct_addr;
  logic [7:0]           r_ct_wdata;

  // First byte address of the current group: 5*g as (g<<2)+g
  logic [BADDR_W-1:0]   w_base_addr;
  assign w_base_addr = (BADDR_W'(r_g) << 2) + BADDR_W'(r_g);

  // Sequencer FSM; all outputs are registered here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_g          <= '0;
      r_j          <= '0;
      r_grp        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_coef_rd_en <= 1'b0;
      r_coef_addr  <= '0;
      r_pk_enable  <= 1'b0;
      r_pk_clear   <= 1'b0;
      r_pk_coeffs  <= '0;
      r_ct_we      <= 1'b0;
      r_ct_addr    <= '0;
      r_ct_wdata   <= '0;
    end else begin
      // Pulse outputs default low every cycle
      r_done       <= 1'b0;
      r_coef_rd_en <= 1'b0;
      r_pk_enable  <= 1'b0;
      r_pk_clear   <= 1'b0;
      r_ct_we      <= 1'b0;
      if (bus.clear) begin
        // Abort from any state; written bytes stay, the packer is flushed
        r_state    <= S_IDLE;
        r_g        <= '0;
        r_j        <= '0;
        r_busy     <= 1'b0;
        r_pk_clear <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_state      <= S_RD;
              r_g          <= '0;
              r_busy       <= 1'b1;
              r_coef_rd_en <= 1'b1;
              r_coef_addr  <= '0;
            end
          end
          S_RD: begin
            r_state <= S_RDW;
          end
          S_RDW: begin
            r_pk_coeffs <= bus.coef_rd_data;
            r_pk_enable <= 1'b1;
            r_state     <= S_LAUNCH;
          end
          S_LAUNCH: begin
            r_state <= S_WAITP;
          end
          S_WAITP: begin
            if (bus.pk_done) begin
              r_grp      <= {bus.pk_group[GRP_W-9:0], 8'h00};
              r_ct_wdata <= bus.pk_group[GRP_W-1 -: 8];
              r_ct_we    <= 1'b1;
              r_ct_addr  <= w_base_addr;
              r_j        <= '0;
              r_state    <= S_WR;
            end
          end
          S_WR: begin
            if (r_j == 3'd4) begin
              if (r_g == G_LAST) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_g          <= r_g + GADDR_W'(1);
                r_coef_rd_en <= 1'b1;
                r_coef_addr  <= r_g + GADDR_W'(1);
                r_state      <= S_RD;
              end
            end else begin
              r_j        <= r_j + 3'd1;
              r_ct_we    <= 1'b1;
              r_ct_addr  <= r_ct_addr + BADDR_W'(1);
              r_ct_wdata <= r_grp[GRP_W-1 -: 8];
              r_grp      <= r_grp << 8;
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.coef_rd_en = r_coef_rd_en;
  assign bus.coef_addr  = r_coef_addr;
  assign bus.pk_enable  = r_pk_enable;
  assign bus.pk_clear   = r_pk_clear;
  assign bus.pk_coeffs  = r_pk_coeffs;
  assign bus.ct_we      = r_ct_we;
  assign bus.ct_addr    = r_ct_addr;
  assign bus.ct_wdata   = r_ct_wdata;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_state_pack_cit_polyvec_seq.sv
// Bench for the polyvec pack sequencer: sync coefficient RAM model,
// behavioural group packer with configurable latency, byte-write
// scoreboard against a reference built from the compression rules.
`timescale 1ns/1ps
module tb_state_pack_cit_polyvec_seq;
  localparam int KYBER_K = 2;
  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;
  localparam int GRP_W   = 40;
  localparam int GADDR_W = 7;
  localparam int BADDR_W = 10;
  localparam int NG      = KYBER_K * KYBER_N / 4;
  localparam int NBYTES  = 5 * NG;
  localparam int Q       = 3329;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  state_pack_cit_polyvec_seq_if #(.COEF_W(COEF_W), .GRP_W(GRP_W),
    .GADDR_W(GADDR_W), .BADDR_W(BADDR_W)) bus ();

  state_pack_cit_polyvec_seq #(.KYBER_K(KYBER_K), .KYBER_N(KYBER_N),
    .COEF_W(COEF_W), .GRP_W(GRP_W), .GADDR_W(GADDR_W), .BADDR_W(BADDR_W))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [47:0] mem    [NG];
  logic [47:0] mem_s1 [NG];
  int   lat_min = 12;
  int   lat_max = 12;
  logic spur_req = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [9:0] compress10(input logic [11:0] c);
    int x;
    x = int'(c);
    if (x >= Q) x = x - Q;
    return 10'(((x * 1024) + Q / 2) / Q);
  endfunction

  function automatic logic [39:0] pack_group(input logic [47:0] w);
    logic [39:0] gr;
    gr = '0;
    for (int k = 0; k < 4; k++)
      gr = (gr << 10) | 40'(compress10(w[47 - 12*k -: 12]));
    return gr;
  endfunction

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int          done_cnt = 0;

  task automatic build_exp();
    logic [39:0] gr;
    exp_q.delete();
    for (int g = 0; g < NG; g++) begin
      gr = pack_group(mem[g]);
      for (int j = 0; j < 5; j++)
        exp_q.push_back({10'(5*g + j), 8'(gr >> (32 - 8*j))});
    end
  endtask

  // ---------------- environment models ----------------
  // Synchronous coefficient RAM
  always @(posedge clk) begin
    if (!reset_n) bus.coef_rd_data <= '0;
    else if (bus.coef_rd_en) bus.coef_rd_data <= mem[bus.coef_addr];
  end

  // Group packer: result after a random latency in [lat_min, lat_max]
  int          pk_cnt  = 0;
  logic        pk_busy = 1'b0;
  logic [39:0] pk_pend = '0;
  always @(posedge clk) begin
    bus.pk_done <= 1'b0;
    if (!reset_n) begin
      pk_busy      <= 1'b0;
      bus.pk_group <= '0;
    end else if (bus.pk_clear) begin
      pk_busy <= 1'b0;
    end else if (bus.pk_enable) begin
      pk_busy <= 1'b1;
      pk_cnt  <= int'($urandom_range(lat_max, lat_min));
      pk_pend <= pack_group(bus.pk_coeffs);
    end else if (pk_busy) begin
      if (pk_cnt <= 1) begin
        pk_busy      <= 1'b0;
        bus.pk_done  <= 1'b1;
        bus.pk_group <= pk_pend;
      end else begin
        pk_cnt <= pk_cnt - 1;
      end
    end
    if (spur_req && reset_n) begin
      bus.pk_done  <= 1'b1;
      bus.pk_group <= 40'({$urandom(), $urandom()});
    end
  end

  // Write / done monitor
  always @(negedge clk) begin
    if (bus.ct_we) got_q.push_back({bus.ct_addr, bus.ct_wdata});
    if (bus.done) done_cnt++;
  end

  // ---------------- scoreboard helper ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic inject_start();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.pk_enable && bus.coef_addr == GADDR_W'(5)) break;
    end
    repeat (3) @(negedge clk);
    check("s3_busy_at_inject", bus.busy, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic inject_spur();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.ct_we && bus.ct_addr == BADDR_W'(14)) break;
    end
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    check("s6_spur_in_rd", {bus.coef_rd_en, bus.pk_done}, 2'b11);
  endtask

  task automatic run_full(input string tag, input bit inj_start, input bit spur);
    int base, d0, busy_low, n;
    bit got_done;
    build_exp();
    base = got_q.size();
    d0 = done_cnt;
    busy_low = 0;
    got_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    fork
      begin
        for (int cyc = 0; cyc < 20000; cyc++) begin
          if (bus.done) begin
            got_done = 1'b1;
            break;
          end
          if (!bus.busy) busy_low++;
          @(negedge clk);
        end
      end
      begin
        if (inj_start) inject_start();
      end
      begin
        if (spur) inject_spur();
      end
    join
    check({tag, "_done_seen"}, got_done, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_low_cycles"}, busy_low, 0);
    check({tag, "_busy_after"}, bus.busy, 0);
    n = got_q.size() - base;
    check({tag, "_nwrites"}, n, NBYTES);
    if (n > NBYTES) n = NBYTES;
    for (int k = 0; k < n; k++)
      check({tag, "_byte"}, got_q[base + k], exp_q[k]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int base, d0, n0;
    logic [39:0] ref2;
    logic [17:0] last_w;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    for (int g = 0; g < NG; g++) mem[g] = 48'({$urandom(), $urandom()});
    mem_s1 = mem;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",       bus.busy, 0);
    check("rst_done",       bus.done, 0);
    check("rst_ct_we",      bus.ct_we, 0);
    check("rst_coef_rd_en", bus.coef_rd_en, 0);
    check("rst_pk_enable",  bus.pk_enable, 0);
    check("rst_pk_clear",   bus.pk_clear, 0);
    check("rst_ct_addr",    bus.ct_addr, 0);
    check("rst_ct_wdata",   bus.ct_wdata, 0);
    check("rst_coef_addr",  bus.coef_addr, 0);
    check("rst_pk_coeffs",  bus.pk_coeffs, 0);
    check("rst_state",      bus.dbg_state, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: full run, fixed latency 12
    run_full("s1", 1'b0, 1'b0);

    // 2: known group 0 -> {0,0,512,0} in 10-bit fields
    mem[0] = {12'd0, 12'd1, 12'd1664, 12'd3328};
    ref2 = 40'h00_0008_0000;
    base = got_q.size();
    run_full("s2", 1'b0, 1'b0);
    for (int j = 0; j < 5; j++)
      if (got_q.size() > base + j)
        check("s2_group0_byte", got_q[base + j], {10'(j), ref2[39 - 8*j -: 8]});

    // 3: extra start during WAITP of group 5
    mem = mem_s1;
    run_full("s3", 1'b1, 1'b0);

    // 4: clear in WR with g = 37, j = 2 (address 187)
    base = got_q.size();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (bus.ct_we && bus.ct_addr == BADDR_W'(187)) break;
      @(negedge clk);
    end
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("s4_ct_we",      bus.ct_we, 0);
    check("s4_pk_clear",   bus.pk_clear, 1);
    check("s4_busy",       bus.busy, 0);
    check("s4_state_idle", bus.dbg_state, 0);
    check("s4_coef_rd_en", bus.coef_rd_en, 0);
    check("s4_pk_enable",  bus.pk_enable, 0);
    check("s4_done",       bus.done, 0);
    @(negedge clk);
    check("s4_pk_clear_one_cycle", bus.pk_clear, 0);
    repeat (10) @(negedge clk);
    check("s4_nwrites_before_clear", got_q.size() - base, 188);
    last_w = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 18'h0;
    check("s4_last_addr", last_w[17:8], 187);
    run_full("s4_restart", 1'b0, 1'b0);

    // 5: asynchronous reset during WAITP of group 10
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (bus.pk_enable && bus.coef_addr == GADDR_W'(10)) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("s5_busy",       bus.busy, 0);
    check("s5_ct_we",      bus.ct_we, 0);
    check("s5_coef_rd_en", bus.coef_rd_en, 0);
    check("s5_pk_clear",   bus.pk_clear, 0);
    check("s5_state",      bus.dbg_state, 0);
    check("s5_coef_addr",  bus.coef_addr, 0);
    check("s5_pk_coeffs",  bus.pk_coeffs, 0);
    d0 = done_cnt;
    n0 = got_q.size();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_no_writes", got_q.size() - n0, 0);
    run_full("s5_restart", 1'b0, 1'b0);

    // 6: random packer latency 8..40 and a spurious pk_done in RD
    lat_min = 8;
    lat_max = 40;
    run_full("s6", 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
